// File: rtl/dco_acq_sequencer.sv
// dco_acq_sequencer: 8-step SAR coarse search on CTW, then saturating bang-bang tracking on FTW with lock detection.
// Optional macro DCO_RELOCK_EN: a fine-word rail hit restarts coarse acquisition instead of saturating.
module dco_acq_sequencer #(
    parameter int CTW_W      = 8,
    parameter int FTW_W      = 8,
    parameter int SETTLE     = 16,
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_RUN = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             UP,
    input  logic             DN,
    output logic [CTW_W-1:0] CTW,
    output logic [FTW_W-1:0] FTW,
    output logic             lock,
    output logic             busy,
    output logic [1:0]       state
);
    localparam int SW = $clog2(SETTLE);
    localparam int NW = SW + 2;
    localparam int BW = (CTW_W > 1) ? $clog2(CTW_W) : 1;
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_RUN + 1);
    localparam logic [CTW_W-1:0] CTW_MID = CTW_W'(1) << (CTW_W - 1);
    localparam logic [FTW_W-1:0] FTW_MID = FTW_W'(1) << (FTW_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COARSE = 2'd1,
        S_FINE   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t                cur_state, nxt_state;
    logic [CTW_W-1:0]      ctw_q, nxt_ctw;
    logic [FTW_W-1:0]      ftw_q, nxt_ftw;
    logic [BW-1:0]         bit_idx, nxt_bit, bit_lo;
    logic [SW-1:0]         settle_cnt, nxt_settle;
    logic signed [NW-1:0]  net, nxt_net, net_sum, step_ext;
    logic [RW-1:0]         rev_cnt, nxt_rev;
    logic [UW-1:0]         run_cnt, nxt_run, run_inc;
    logic                  last_up, nxt_last_up, last_vld, nxt_last_vld;
    logic                  step_up, step_dn, step_nz, rail, reversal, same_dir, relock;

    assign CTW   = ctw_q;
    assign FTW   = ftw_q;
    assign state = cur_state;
    assign lock  = (cur_state == S_LOCKED);
    assign busy  = (cur_state != S_IDLE);

    always_comb begin
        step_up  = UP & ~DN;
        step_dn  = DN & ~UP;
        step_nz  = step_up | step_dn;
        step_ext = step_up ? NW'(1) : (step_dn ? {NW{1'b1}} : '0);
        net_sum  = net + step_ext;
        rail     = (step_up && ftw_q == '1) || (step_dn && ftw_q == '0);
        same_dir = last_vld && (last_up == step_up);
        reversal = step_nz && last_vld && (last_up != step_up);
        run_inc  = !same_dir ? UW'(1) :
                   ((run_cnt == UW'(UNLOCK_RUN)) ? run_cnt : run_cnt + 1'b1);
        bit_lo   = bit_idx - 1'b1;
        relock   = 1'b0;

        nxt_state    = cur_state;
        nxt_ctw      = ctw_q;
        nxt_ftw      = ftw_q;
        nxt_bit      = bit_idx;
        nxt_settle   = settle_cnt;
        nxt_net      = net;
        nxt_rev      = rev_cnt;
        nxt_run      = run_cnt;
        nxt_last_up  = last_up;
        nxt_last_vld = last_vld;

        case (cur_state)
            S_IDLE: ;
            S_COARSE: begin
                nxt_net    = net_sum;
                nxt_settle = settle_cnt + 1'b1;
                // Decision includes the vote sampled on this final window cycle.
                if (settle_cnt == SW'(SETTLE - 1)) begin
                    nxt_net    = '0;
                    nxt_settle = '0;
                    if (net_sum[NW-1]) nxt_ctw[bit_idx] = 1'b0;
                    if (bit_idx == '0) begin
                        nxt_state = S_FINE;
                    end else begin
                        nxt_bit         = bit_lo;
                        nxt_ctw[bit_lo] = 1'b1;
                    end
                end
            end
            S_FINE, S_LOCKED: begin
                if (step_nz) begin
                    nxt_last_up  = step_up;
                    nxt_last_vld = 1'b1;
                    nxt_run      = run_inc;
                end
                if (rail) begin
`ifdef DCO_RELOCK_EN
                    relock = 1'b1;
`else
                    nxt_state = S_FINE;
                    nxt_rev   = '0;
`endif
                end else begin
                    if (step_up)      nxt_ftw = ftw_q + 1'b1;
                    else if (step_dn) nxt_ftw = ftw_q - 1'b1;
                    if (cur_state == S_FINE && reversal) begin
                        nxt_rev = rev_cnt + 1'b1;
                        if (rev_cnt == RW'(LOCK_CNT - 1)) nxt_state = S_LOCKED;
                    end else if (cur_state == S_LOCKED && step_nz && run_inc == UW'(UNLOCK_RUN)) begin
                        nxt_state = S_FINE;
                        nxt_rev   = '0;
                    end
                end
            end
            default: ;
        endcase

        // Fresh acquisition: from a start pulse in any state, or a relock after a rail hit.
        if (start || relock) begin
            nxt_state    = S_COARSE;
            nxt_ctw      = CTW_MID;
            nxt_ftw      = FTW_MID;
            nxt_bit      = BW'(CTW_W - 1);
            nxt_settle   = '0;
            nxt_net      = '0;
            nxt_rev      = '0;
            nxt_run      = '0;
            nxt_last_up  = 1'b0;
            nxt_last_vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= S_IDLE;
            ctw_q      <= CTW_MID;
            ftw_q      <= FTW_MID;
            bit_idx    <= BW'(CTW_W - 1);
            settle_cnt <= '0;
            net        <= '0;
            rev_cnt    <= '0;
            run_cnt    <= '0;
            last_up    <= 1'b0;
            last_vld   <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            ctw_q      <= nxt_ctw;
            ftw_q      <= nxt_ftw;
            bit_idx    <= nxt_bit;
            settle_cnt <= nxt_settle;
            net        <= nxt_net;
            rev_cnt    <= nxt_rev;
            run_cnt    <= nxt_run;
            last_up    <= nxt_last_up;
            last_vld   <= nxt_last_vld;
        end
    end
endmodule

// File: tb/tb_dco_acq_sequencer.sv
// tb_dco_acq_sequencer: randomized and directed stimulus for dco_acq_sequencer against a behavioural model.
// Honours DCO_RELOCK_EN the same way the design does.
module tb_dco_acq_sequencer;
    localparam int SETTLE     = 16;
    localparam int LOCK_CNT   = 32;
    localparam int UNLOCK_RUN = 8;
    localparam int FMAX       = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       UP = 1'b0;
    logic       DN = 1'b0;
    logic [7:0] CTW, FTW;
    logic       lock, busy;
    logic [1:0] state;
    logic [19:0] act_v;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: plain integers plus a history of nonzero fine-step directions.
    int         m_state;
    logic [7:0] m_ctw;
    int         m_ftw, m_net, m_cyc, m_rev;
    int         dirs[$];

    dco_acq_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .UP(UP), .DN(DN),
        .CTW(CTW), .FTW(FTW), .lock(lock), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;
    assign act_v = {CTW, FTW, lock, busy, state};

    function automatic logic [19:0] exp_vec();
        logic [7:0] f;
        logic [1:0] s;
        f = m_ftw[7:0];
        s = m_state[1:0];
        return {m_ctw, f, m_state == 3, m_state != 0, s};
    endfunction

    task automatic model_entry();
        m_state = 1; m_ctw = 8'h80; m_ftw = 128;
        m_net = 0; m_cyc = 0; m_rev = 0;
        dirs.delete();
    endtask

    task automatic model_edge(input logic r, input logic s, input logic u, input logic d);
        int  step, b, run;
        bit  rail;
        step = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
        if (r) begin
            model_entry();
            m_state = 0;
        end else if (s) begin
            model_entry();
        end else if (m_state == 1) begin
            m_net += step;
            if (m_cyc % SETTLE == SETTLE - 1) begin
                b = 7 - m_cyc / SETTLE;
                if (m_net < 0) m_ctw[b] = 1'b0;
                if (b == 0) m_state = 2;
                else m_ctw[b-1] = 1'b1;
                m_net = 0;
            end
            m_cyc++;
        end else if (m_state >= 2 && step != 0) begin
            rail = (step > 0 && m_ftw == FMAX) || (step < 0 && m_ftw == 0);
            dirs.push_back(step);
            if (rail) begin
`ifdef DCO_RELOCK_EN
                model_entry();
`else
                m_state = 2;
                m_rev = 0;
`endif
            end else begin
                m_ftw += step;
                if (m_state == 2) begin
                    if (dirs.size() >= 2 && dirs[dirs.size()-2] != step) begin
                        m_rev++;
                        if (m_rev == LOCK_CNT) m_state = 3;
                    end
                end else begin
                    run = 0;
                    for (int k = dirs.size() - 1; k >= 0 && dirs[k] == step; k--) run++;
                    if (run >= UNLOCK_RUN) begin
                        m_state = 2;
                        m_rev = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic s, input logic u, input logic d);
        start = s; UP = u; DN = d;
        @(posedge clk);
        model_edge(reset, s, u, d);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        n_chk++;
        if (act_v !== {8'h80, 8'h80, 1'b0, 1'b0, 2'd0})
            $display("FAIL reset_values got=%h exp=%h", act_v, {8'h80, 8'h80, 1'b0, 1'b0, 2'd0});
        else n_pass++;
        tick(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (act_v !== exp_vec()) $display("FAIL idle_hold got=%h exp=%h", act_v, exp_vec());
        else n_pass++;
    endtask

    task automatic test_coarse_const(input string name, input logic u, input logic d, input logic [7:0] exp_ctw);
        tick(1'b1, u, d);
        n_chk++;
        if (state !== 2'd1 || CTW !== 8'h80)
            $display("FAIL %s_entry got state=%0d ctw=%h exp state=1 ctw=80", name, state, CTW);
        else n_pass++;
        for (int i = 1; i <= 8 * SETTLE; i++) begin
            tick(1'b0, u, d);
            n_chk++;
            if (act_v !== exp_vec()) $display("FAIL %s cyc=%0d got=%h exp=%h", name, i, act_v, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (CTW !== exp_ctw || state !== 2'd2)
            $display("FAIL %s_final got ctw=%h state=%0d exp ctw=%h state=2", name, CTW, state, exp_ctw);
        else n_pass++;
    endtask

    task automatic test_coarse_random();
        logic [7:0] exp_bits;
        int wsum, p;
        logic u, d;
        exp_bits = 8'h00;
        tick(1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 8; w++) begin
            wsum = 0;
            p = $urandom_range(0, 100);
            for (int c = 0; c < SETTLE; c++) begin
                u = ($urandom_range(0, 99) < p);
                d = ($urandom_range(0, 99) >= p);
                if ($urandom_range(0, 7) == 0) d = u;
                tick(1'b0, u, d);
                wsum += (u && !d) ? 1 : ((d && !u) ? -1 : 0);
                n_chk++;
                if (act_v !== exp_vec()) $display("FAIL coarse_rand w=%0d c=%0d got=%h exp=%h", w, c, act_v, exp_vec());
                else n_pass++;
            end
            exp_bits[7-w] = (wsum >= 0);
        end
        n_chk++;
        if (CTW !== exp_bits || state !== 2'd2)
            $display("FAIL coarse_rand_final got ctw=%h state=%0d exp ctw=%h state=2", CTW, state, exp_bits);
        else n_pass++;
    endtask

    task automatic test_lock_unlock();
        logic u;
        for (int i = 1; i <= LOCK_CNT + 1; i++) begin
            u = i[0];
            tick(1'b0, u, !u);
            n_chk++;
            if (lock !== (i - 1 >= LOCK_CNT) || act_v !== exp_vec())
                $display("FAIL lock_alt i=%0d got=%h exp=%h", i, act_v, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (state !== 2'd3 || FTW !== 8'h81) $display("FAIL lock_entry got state=%0d ftw=%h exp state=3 ftw=81", state, FTW);
        else n_pass++;
        for (int j = 1; j <= UNLOCK_RUN; j++) begin
            tick(1'b0, 1'b0, 1'b1);
            n_chk++;
            if (lock !== (j < UNLOCK_RUN) || act_v !== exp_vec())
                $display("FAIL unlock_run j=%0d got=%h exp=%h", j, act_v, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (state !== 2'd2 || FTW !== 8'h79) $display("FAIL unlock_final got state=%0d ftw=%h exp state=2 ftw=79", state, FTW);
        else n_pass++;
    endtask

    task automatic test_restart();
        int n;
        logic u;
        n = 0;
        u = 1'b1;
        while (lock !== 1'b1 && n < 100) begin
            tick(1'b0, u, !u);
            u = !u;
            n++;
        end
        n_chk++;
        if (lock !== 1'b1 || n != LOCK_CNT) $display("FAIL relock_steps got lock=%b after %0d exp lock=1 after %0d", lock, n, LOCK_CNT);
        else n_pass++;
        tick(1'b1, 1'b0, 1'b0);
        n_chk++;
        if (act_v !== {8'h80, 8'h80, 1'b0, 1'b1, 2'd1})
            $display("FAIL restart got=%h exp=%h", act_v, {8'h80, 8'h80, 1'b0, 1'b1, 2'd1});
        else n_pass++;
    endtask

    task automatic test_rail();
        int n;
        for (int i = 0; i < 8 * SETTLE; i++) tick(1'b0, 1'b1, 1'b0);
        n = 0;
        while (FTW !== 8'hFF && n < 300) begin
            tick(1'b0, 1'b1, 1'b0);
            n++;
        end
        n_chk++;
        if (FTW !== 8'hFF || n != 127) $display("FAIL rail_climb got ftw=%h after %0d exp ftw=ff after 127", FTW, n);
        else n_pass++;
        tick(1'b0, 1'b1, 1'b0);
        n_chk++;
`ifdef DCO_RELOCK_EN
        if (act_v !== {8'h80, 8'h80, 1'b0, 1'b1, 2'd1})
            $display("FAIL rail_hit got=%h exp=%h", act_v, {8'h80, 8'h80, 1'b0, 1'b1, 2'd1});
        else n_pass++;
`else
        if (FTW !== 8'hFF || state !== 2'd2 || lock !== 1'b0)
            $display("FAIL rail_hit got ftw=%h state=%0d lock=%b exp ftw=ff state=2 lock=0", FTW, state, lock);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_coarse();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        n_chk++;
        if (act_v !== {8'h80, 8'h80, 1'b0, 1'b0, 2'd0})
            $display("FAIL reset_mid_coarse got=%h exp=%h", act_v, {8'h80, 8'h80, 1'b0, 1'b0, 2'd0});
        else n_pass++;
    endtask

    task automatic test_random_fine();
        int mode;
        logic u, d, s, alt;
        alt = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 12; w++) begin
            mode = $urandom_range(0, 3);
            for (int c = 0; c < 150; c++) begin
                case (mode)
                    0: begin alt = !alt; u = alt; d = !alt; if ($urandom_range(0, 9) == 0) d = u; end
                    1: begin u = ($urandom_range(0, 9) != 0); d = !u; end
                    2: begin d = ($urandom_range(0, 9) != 0); u = !d; end
                    default: begin u = $urandom_range(0, 1); d = $urandom_range(0, 1); end
                endcase
                s = ($urandom_range(0, 599) == 0);
                tick(s, u, d);
                n_chk++;
                if (act_v !== exp_vec()) $display("FAIL random w=%0d c=%0d mode=%0d got=%h exp=%h", w, c, mode, act_v, exp_vec());
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_coarse_const("coarse_up", 1'b1, 1'b0, 8'hFF);
        test_coarse_const("coarse_dn", 1'b0, 1'b1, 8'h00);
        test_coarse_const("coarse_both", 1'b1, 1'b1, 8'hFF);
        test_coarse_random();
        test_coarse_const("coarse_up2", 1'b1, 1'b0, 8'hFF);
        test_lock_unlock();
        test_restart();
        test_rail();
        test_reset_mid_coarse();
        test_random_fine();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
